// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole score/lives evaluator.
package whack_pkg;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    LOCKED    = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  localparam int MISS_W   = 8;
  localparam int STREAK_W = 8;

  localparam logic [1:0] PTS_NORMAL = 2'd1;
  localparam logic [1:0] PTS_BONUS  = 2'd2;

  // Enough bits to hold every value from 0 up to max_lives.
  function automatic int lives_w(input int max_lives);
    return (max_lives < 1) ? 1 : $clog2(max_lives + 1);
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Post-miss lockout counter: start arms it at 0, done pulses on its final
// (LOCK_CYCLES-th) cycle, clear aborts it synchronously.
module lockout_timer #(
  parameter int LOCK_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  output logic done
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             running;

  assign done = running && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (done) begin
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_eval_multi.sv
// Score/lives evaluator between button decoder and mole generator.
// Define STREAK_BONUS_EN to award bonus points on long hit streaks.
module score_eval_multi
  import whack_pkg::*;
#(
  parameter int POS_W         = 3,
  parameter int SCORE_W       = 8,
  parameter int LOCK_CYCLES   = 100000000,
  parameter int MAX_LIVES     = 3,
  parameter int STREAK_THRESH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           restart,
  input  logic [POS_W-1:0]               user_guess,
  input  logic [POS_W-1:0]               mole_pos,
  input  logic                           mole_valid,
  input  logic                           mole_change,
  input  logic                           eval_now,
  output logic [SCORE_W-1:0]             score,
  output logic [MISS_W-1:0]              misses,
  output logic [lives_w(MAX_LIVES)-1:0]  lives,
  output logic [STREAK_W-1:0]            streak,
  output logic                           guess_correct,
  output logic                           guess_wrong,
  output logic                           guess_now,
  output logic                           game_over,
  output state_e                         state_dbg
);

  localparam int LIVES_W = lives_w(MAX_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
`ifdef STREAK_BONUS_EN
  localparam logic [1:0] STREAK_PTS = PTS_BONUS;
`else
  localparam logic [1:0] STREAK_PTS = PTS_NORMAL;
`endif

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_d;
  logic [MISS_W-1:0]    misses_d;
  logic [LIVES_W-1:0]   lives_d, lives_dec;
  logic [STREAK_W-1:0]  streak_d;
  logic                 hit_latched, hit_latched_d;
  logic                 correct_d, wrong_d;
  logic                 timer_start, timer_done;
  logic                 match, eff_latched;
  logic [1:0]           pts;
  logic [SCORE_W:0]     score_sum;

  // A coinciding mole_change means this evaluation targets the new mole.
  assign eff_latched = hit_latched && !mole_change;
  assign match       = mole_valid && (user_guess == mole_pos);
  assign pts         = (int'(streak) >= STREAK_THRESH) ? STREAK_PTS : PTS_NORMAL;
  assign score_sum   = {1'b0, score} + (SCORE_W + 1)'(pts);
  assign lives_dec   = lives - LIVES_W'(1);
  assign state_dbg   = state_q;

  lockout_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lockout_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(restart),
    .start(timer_start),
    .done (timer_done)
  );

  always_comb begin
    state_d       = state_q;
    score_d       = score;
    misses_d      = misses;
    lives_d       = lives;
    streak_d      = streak;
    hit_latched_d = eff_latched;
    correct_d     = 1'b0;
    wrong_d       = 1'b0;
    timer_start   = 1'b0;
    case (state_q)
      READY: begin
        if (eval_now) begin
          if (match && !eff_latched) begin
            correct_d     = 1'b1;
            score_d       = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
            streak_d      = (streak == '1) ? streak : streak + STREAK_W'(1);
            hit_latched_d = 1'b1;
          end else if (!match) begin
            wrong_d  = 1'b1;
            misses_d = (misses == '1) ? misses : misses + MISS_W'(1);
            streak_d = '0;
            lives_d  = lives_dec;
            if (lives_dec == '0) begin
              state_d = GAME_OVER;
            end else begin
              state_d     = LOCKED;
              timer_start = 1'b1;
            end
          end
        end
      end
      LOCKED: begin
        if (timer_done) state_d = READY;
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= READY;
      score         <= '0;
      misses        <= '0;
      lives         <= LIVES_W'(MAX_LIVES);
      streak        <= '0;
      hit_latched   <= 1'b0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      guess_now     <= 1'b1;
      game_over     <= 1'b0;
    end else if (restart) begin
      state_q       <= READY;
      score         <= '0;
      misses        <= '0;
      lives         <= LIVES_W'(MAX_LIVES);
      streak        <= '0;
      hit_latched   <= 1'b0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      guess_now     <= 1'b1;
      game_over     <= 1'b0;
    end else begin
      state_q       <= state_d;
      score         <= score_d;
      misses        <= misses_d;
      lives         <= lives_d;
      streak        <= streak_d;
      hit_latched   <= hit_latched_d;
      guess_correct <= correct_d;
      guess_wrong   <= wrong_d;
      guess_now     <= (state_d == READY);
      game_over     <= (state_d == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_score_eval_multi.sv
// Bench for score_eval_multi: directed table, hand sequences and random
// stimulus, all checked against a behavioural game model.
module tb_score_eval_multi;
  import whack_pkg::*;

  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart, mole_valid, mole_change, eval_now;
  logic [2:0] user_guess, mole_pos;

  logic [7:0] score, misses, streak;
  logic [1:0] lives;
  logic       guess_correct, guess_wrong, guess_now, game_over;
  state_e     state_dbg;

  logic [3:0] s4_score;
  logic [7:0] s4_misses, s4_streak;
  logic [1:0] s4_lives;
  logic       s4_gc, s4_gw, s4_gn, s4_go;
  state_e     s4_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  score_eval_multi #(.POS_W(3), .SCORE_W(8), .LOCK_CYCLES(LOCK), .MAX_LIVES(3), .STREAK_THRESH(4)) dut (
    .clk(clk), .rst(rst), .restart(restart), .user_guess(user_guess), .mole_pos(mole_pos),
    .mole_valid(mole_valid), .mole_change(mole_change), .eval_now(eval_now),
    .score(score), .misses(misses), .lives(lives), .streak(streak),
    .guess_correct(guess_correct), .guess_wrong(guess_wrong), .guess_now(guess_now),
    .game_over(game_over), .state_dbg(state_dbg));

  score_eval_multi #(.POS_W(3), .SCORE_W(4), .LOCK_CYCLES(LOCK), .MAX_LIVES(3), .STREAK_THRESH(4)) dut_s4 (
    .clk(clk), .rst(rst), .restart(restart), .user_guess(user_guess), .mole_pos(mole_pos),
    .mole_valid(mole_valid), .mole_change(mole_change), .eval_now(eval_now),
    .score(s4_score), .misses(s4_misses), .lives(s4_lives), .streak(s4_streak),
    .guess_correct(s4_gc), .guess_wrong(s4_gw), .guess_now(s4_gn),
    .game_over(s4_go), .state_dbg(s4_state));

  // ---------------- reference model ----------------
  int m_score, m_score4, m_misses, m_lives, m_streak, m_lock_left;
  bit m_over, m_latched, m_gc, m_gw;

  function automatic void model_reset();
    m_score = 0; m_score4 = 0; m_misses = 0; m_lives = 3; m_streak = 0;
    m_lock_left = 0; m_over = 0; m_latched = 0; m_gc = 0; m_gw = 0;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic void model_step();
    bit already;
    int pts;
    if (restart) begin
      model_reset();
      return;
    end
    m_gc = 0;
    m_gw = 0;
    already = m_latched && !mole_change;
    if (mole_change) m_latched = 0;
    if (m_over) begin
    end else if (m_lock_left > 0) begin
      m_lock_left--;
    end else if (eval_now) begin
      if (mole_valid && user_guess == mole_pos) begin
        if (!already) begin
`ifdef STREAK_BONUS_EN
          pts = (m_streak >= 4) ? 2 : 1;
`else
          pts = 1;
`endif
          m_score   = sat(m_score + pts, 255);
          m_score4  = sat(m_score4 + pts, 15);
          m_streak  = sat(m_streak + 1, 255);
          m_latched = 1;
          m_gc      = 1;
        end
      end else begin
        m_gw     = 1;
        m_misses = sat(m_misses + 1, 255);
        m_streak = 0;
        m_lives--;
        if (m_lives == 0) m_over = 1;
        else m_lock_left = LOCK;
      end
    end
  endfunction

  function automatic logic [63:0] pack_dut();
    return {34'b0, score, misses, lives, streak, guess_correct, guess_wrong, guess_now, game_over};
  endfunction

  function automatic logic [63:0] pack_model();
    return {34'b0, 8'(m_score), 8'(m_misses), 2'(m_lives), 8'(m_streak),
            m_gc, m_gw, (!m_over && m_lock_left == 0), m_over};
  endfunction

  // ---------------- checking / driving ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model", pack_dut(), pack_model());
    check("score4", 64'(s4_score), 64'(m_score4));
  endtask

  task automatic idle_inputs();
    restart = 0; eval_now = 0; mole_change = 0; mole_valid = 1;
    user_guess = 0; mole_pos = 0;
  endtask

  task automatic hit_fresh(input logic [2:0] p);
    mole_change = 1; mole_pos = p; user_guess = p; mole_valid = 1; eval_now = 1;
    cycle();
    mole_change = 0; eval_now = 0;
  endtask

  task automatic miss_and_wait();
    mole_change = 1; mole_pos = 6; user_guess = 1; mole_valid = 1; eval_now = 1;
    cycle();
    mole_change = 0; eval_now = 0;
    for (int i = 0; i < 40; i++) begin
      if (guess_now || game_over) break;
      cycle();
    end
    check("lock_release", 64'(guess_now | game_over), 64'd1);
  endtask

  typedef struct {
    logic       chg, ev, vld;
    logic [2:0] pos, gs;
    logic [7:0] e_score, e_streak;
    logic [1:0] e_lives;
    logic [7:0] e_miss;
    logic       e_gc, e_gw, e_gn;
  } vec_t;

  vec_t tbl[5];
  logic [63:0] reset_pack;
  int lock_low;
  int bonus_exp[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_pack = {34'b0, 8'd0, 8'd0, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[0] = '{1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 8'd1, 8'd1, 2'd3, 8'd0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 8'd1, 8'd1, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 8'd1, 8'd1, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 3'd6, 3'd2, 8'd1, 8'd0, 2'd2, 8'd1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 3'd6, 3'd6, 8'd1, 8'd0, 2'd2, 8'd1, 1'b0, 1'b0, 1'b0};
`ifdef STREAK_BONUS_EN
    bonus_exp = '{1, 2, 3, 4, 6, 8};
`else
    bonus_exp = '{1, 2, 3, 4, 5, 6};
`endif

    // clock/reset
    rst = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1;
    check("reset_values", pack_dut(), reset_pack);
    check("reset_state", 64'(state_dbg), 64'(READY));

    // hit, idle, repeat whack, miss on new mole, eval during lockout
    for (int i = 0; i < 5; i++) begin
      mole_change = tbl[i].chg; eval_now = tbl[i].ev; mole_valid = tbl[i].vld;
      mole_pos = tbl[i].pos; user_guess = tbl[i].gs;
      cycle();
      check($sformatf("table_%0d", i), pack_dut(),
            {34'b0, tbl[i].e_score, tbl[i].e_miss, tbl[i].e_lives, tbl[i].e_streak,
             tbl[i].e_gc, tbl[i].e_gw, tbl[i].e_gn, 1'b0});
    end

    // lockout length, with a would-be hit offered every cycle
    lock_low = 2;
    for (int i = 0; i < 100; i++) begin
      if (guess_now) break;
      cycle();
      if (!guess_now) lock_low++;
    end
    eval_now = 0; mole_change = 0;
    check("lockout_cycles", 64'(lock_low), 64'(LOCK));
    check("score_after_lock", 64'(score), 64'd1);

    // drain remaining lives, then game over is sticky
    miss_and_wait();
    miss_and_wait();
    mole_pos = 3; user_guess = 3; mole_valid = 1; eval_now = 1;
    repeat (5) cycle();
    eval_now = 0;
    check("game_over_lives", 64'({lives, game_over, guess_now}), 64'({2'd0, 1'b1, 1'b0}));
    restart = 1;
    cycle();
    restart = 0;
    check("restart_values", pack_dut(), reset_pack);

    // score saturation on the narrow instance
    for (int i = 0; i < 20; i++) hit_fresh(3'(i));
    check("score4_saturated", 64'(s4_score), 64'd15);

    // streak bonus sequence
    restart = 1;
    cycle();
    restart = 0;
    for (int i = 0; i < 6; i++) begin
      hit_fresh(3'(i + 1));
      check($sformatf("bonus_score_%0d", i), 64'(score), 64'(bonus_exp[i]));
    end

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      restart     = ($urandom_range(0, 79) == 0);
      mole_valid  = ($urandom_range(0, 4) != 0);
      mole_change = ($urandom_range(0, 4) == 0);
      eval_now    = $urandom_range(0, 1);
      mole_pos    = 3'($urandom_range(0, 3));
      user_guess  = 3'($urandom_range(0, 3));
      cycle();
    end
    idle_inputs();
    restart = 1;
    cycle();
    restart = 0;

    // asynchronous reset in the middle of a lockout
    mole_change = 1; mole_pos = 6; user_guess = 1; eval_now = 1;
    cycle();
    mole_change = 0; eval_now = 0;
    repeat (7) cycle();
    check("mid_lock_guess_now", 64'(guess_now), 64'd0);
    #2 rst = 0;
    #1;
    model_reset();
    check("async_reset_values", pack_dut(), reset_pack);
    check("async_reset_state", 64'(state_dbg), 64'(READY));
    @(posedge clk);
    #1 rst = 1;
    cycle();
    check("after_reset_guess_now", 64'(guess_now), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_eval_multi.md
Name: score_eval_multi

Overview:
- Parametrised successor score/lives evaluator for the whack-a-mole game. It sits between the button decoder (user_guess, eval_now) and the mole generator (mole_pos, mole_valid, mole_change), and drives the score display and the LED feedback logic.
- Adds configurable hole count and score width, a lives budget with a game-over state, and a per-mole single-hit guard.
- Adds a miss counter, a hit-streak tracker, a configurable lockout after a miss, and a synchronous restart.

Parameters:
POS_W, 3, width of mole/guess position (up to 2^POS_W holes)
SCORE_W, 8, score width; score saturates
LOCK_CYCLES, 100000000, lockout length in clk cycles after a miss (>=1)
MAX_LIVES, 3, lives at reset/restart (>=1)
STREAK_THRESH, 4, consecutive hits before bonus applies (used only with STREAK_BONUS_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
restart  in  1  synchronous pulse; same effect as reset
user_guess  in  POS_W  hole selected by player
mole_pos  in  POS_W  current mole hole
mole_valid  in  1  mole currently visible
mole_change  in  1  1-cycle pulse: new mole presented
eval_now  in  1  1-cycle pulse: evaluate user_guess
score  out  SCORE_W  accumulated score
misses  out  8  miss count, saturating at 255
lives  out  clog2(MAX_LIVES+1)  remaining lives
streak  out  8  consecutive hits, saturating at 255
guess_correct  out  1  1-cycle pulse on hit
guess_wrong  out  1  1-cycle pulse on miss
guess_now  out  1  high when evaluator accepts guesses
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (rst low, async) or restart (sync, sampled high):
  - score=0, misses=0, streak=0, lives=MAX_LIVES.
  - guess_correct=0, guess_wrong=0, guess_now=1, game_over=0.
  - hit_latched=0, lock counter=0, state=READY.
  - restart has priority over every other input in its cycle.
- All outputs are registered. Response pulses appear on the edge that samples eval_now, i.e. the cycle after eval_now is presented.
- States: READY, LOCKED, GAME_OVER.
- READY, eval_now=1:
  - Hit: mole_valid=1, user_guess==mole_pos, and effective hit_latched=0.
    - guess_correct pulse; score += points, saturating at 2^SCORE_W-1; streak+1; hit_latched=1.
  - Repeat whack on an already-hit mole (hit_latched=1 with a matching guess): no-op. No pulse, no score change.
  - Any other case (mismatch, or mole_valid=0) is a miss:
    - guess_wrong pulse; misses+1; streak=0; lives-1.
    - If the new lives value is 0: go to GAME_OVER.
    - Otherwise: go to LOCKED with counter=0 and guess_now=0 in the same edge.
- LOCKED:
  - Counter increments every cycle; eval_now is ignored.
  - When the counter reaches LOCK_CYCLES-1: go to READY and set guess_now=1 on the next edge. The lockout is exactly LOCK_CYCLES cycles with guess_now=0.
  - mole_change does not end the lockout.
- GAME_OVER:
  - game_over=1, guess_now=0, all eval_now ignored.
  - Sticky until reset or restart.
- mole_change clears hit_latched. When mole_change and eval_now coincide, hit_latched is treated as 0 for that evaluation, and the evaluation uses the mole_pos presented that cycle.
- guess_correct and guess_wrong never both assert. Each is high for exactly one cycle per accepted eval_now.
- Reset asserted mid-lockout aborts it immediately and returns to READY values.

Optional Feature:
- Macro: STREAK_BONUS_EN.
- Defined: a hit adds 2 points when the pre-increment streak is >= STREAK_THRESH, otherwise 1. The bonus also saturates.
- Undefined: every hit adds 1. The streak output is still maintained.

Decomposition:
- Package whack_pkg:
  - state enum (READY, LOCKED, GAME_OVER).
  - Constants: MISS_W=8, STREAK_W=8, PTS_NORMAL=1, PTS_BONUS=2.
  - Function for the lives width.
- Sub-module lockout_timer (LOCK_CYCLES parameter):
  - Inputs: start, clk, rst.
  - Output: done pulse on the final cycle.
- The main module holds the FSM and the counters.

Test Plan:
1. Reset release; mole_pos=5, mole_valid=1; eval_now with user_guess=5 -> guess_correct one cycle later; score=1, streak=1; second eval on same mole -> no pulse, score stays 1.
2. mole_change then eval_now with user_guess=2, mole_pos=6 -> guess_wrong pulse; lives=2, misses=1, streak=0; guess_now=0 for exactly LOCK_CYCLES (bench uses 16) cycles; evals during lockout are ignored.
3. Three misses with LOCK_CYCLES=16 -> lives=0, game_over=1; later evals ignored; restart pulse -> lives=3, score=0, guess_now=1.
4. SCORE_W=4, 20 hits on fresh moles -> score holds at 15.
5. STREAK_BONUS_EN, STREAK_THRESH=4: 6 consecutive hits -> score 1,2,3,4,6,8.
6. rst low mid-lockout (counter=7) -> all outputs return to reset values asynchronously; after release, guess_now=1.
